// File: rtl/wifi_ahb_slave_if.sv
// wifi_ahb_slave_if: AHB-Lite slave front end for the WIFI PHY peripheral.
// Define WIFI_AHB_RANGE_CHK_EN to reject memory accesses past the window.
module wifi_ahb_slave_if #(
  parameter int ADDR_AHB   = 12,
  parameter int ADDR_SLIC  = 10,
  parameter int offset     = 'h10,
  parameter int MEM_RD_LAT = 1
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                HSEL,
  input  logic [ADDR_AHB-1:0] HADDR,
  input  logic [1:0]          HTRANS,
  input  logic                HWRITE,
  input  logic [2:0]          HSIZE,
  input  logic                HREADY,
  input  logic [31:0]         HWDATA,
  output logic                HREADYOUT,
  output logic                HRESP,
  output logic [31:0]         HRDATA,
  output logic [ADDR_AHB-1:0] addr_o,
  output logic [31:0]         wdata_o,
  output logic                write_enable,
  output logic                read_enable,
  input  logic [31:0]         reg_rdata,
  input  logic [31:0]         mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    MEM_WAIT,
    ERR1,
    ERR2
  } state_t;

  localparam logic [2:0] LAT_M1 = 3'(MEM_RD_LAT - 1);

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [ADDR_AHB-1:0] addr_q;
  logic [31:0]         wdata_q;
  logic                wr_q, mem_q;
  logic                accept, take, capture;
  logic                in_reg, range_err, err;
  logic [31:0]         haddr_w;
  logic                unused_ok;

  assign unused_ok = HTRANS[0];
  assign haddr_w   = 32'(HADDR);
  assign in_reg    = haddr_w < 32'(offset);

`ifdef WIFI_AHB_RANGE_CHK_EN
  localparam int unsigned MEM_END = offset + (1 << ADDR_SLIC);
  assign range_err = ~in_reg & (haddr_w >= 32'(MEM_END));
`else
  assign range_err = 1'b0;
`endif

  assign err = (HSIZE != 3'b010) | (HADDR[1:0] != 2'b00) | range_err;

  assign accept  = HSEL & HREADY & HTRANS[1];
  assign capture = take & accept;

  assign addr_o  = addr_q;
  assign wdata_o = write_enable ? HWDATA : wdata_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    HREADYOUT    = 1'b1;
    HRESP        = 1'b0;
    HRDATA       = '0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    take         = 1'b0;
    unique case (state_q)
      IDLE: take = 1'b1;
      DATA: begin
        if (wr_q) begin
          write_enable = 1'b1;
          take         = 1'b1;
        end else begin
          read_enable = 1'b1;
          if (mem_q) begin
            HREADYOUT = 1'b0;
            cnt_d     = LAT_M1;
            state_d   = MEM_WAIT;
          end else begin
            HRDATA = reg_rdata;
            take   = 1'b1;
          end
        end
      end
      MEM_WAIT: begin
        if (cnt_q != 3'd0) begin
          HREADYOUT = 1'b0;
          cnt_d     = cnt_q - 3'd1;
        end else begin
          HRDATA = mem_rdata;
          take   = 1'b1;
        end
      end
      ERR1: begin
        HRESP     = 1'b1;
        HREADYOUT = 1'b0;
        state_d   = ERR2;
      end
      ERR2: begin
        HRESP = 1'b1;
        take  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // completing cycle doubles as the next address phase
    if (take) begin
      if (accept) state_d = err ? ERR1 : DATA;
      else        state_d = IDLE;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      mem_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        addr_q <= HADDR;
        wr_q   <= HWRITE;
        mem_q  <= ~in_reg;
      end
      if (write_enable) wdata_q <= HWDATA;
    end
  end

endmodule

// File: tb/tb_wifi_ahb_slave_if.sv
// tb_wifi_ahb_slave_if: directed table, reset corners and random traffic
// checked against a transfer-level model of wifi_ahb_slave_if.
module tb_wifi_ahb_slave_if;

  localparam int LAT = 2;
  localparam int OFS = 'h10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel, hwrite, hready, hreadyout, hresp, we, re;
  logic [11:0] haddr, addr_o;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] hwdata, hrdata, wdata_o, reg_rdata, mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign hready = hreadyout;

  wifi_ahb_slave_if #(
    .ADDR_AHB(12), .ADDR_SLIC(10), .offset(OFS), .MEM_RD_LAT(LAT)
  ) dut (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HREADY(hready),
    .HWDATA(hwdata), .HREADYOUT(hreadyout), .HRESP(hresp),
    .HRDATA(hrdata), .addr_o(addr_o), .wdata_o(wdata_o),
    .write_enable(we), .read_enable(re),
    .reg_rdata(reg_rdata), .mem_rdata(mem_rdata)
  );

  typedef struct {
    bit          wr;
    logic [11:0] a;
    logic [2:0]  sz;
    logic [31:0] d;
  } tr_t;

  // one expected data-phase cycle
  typedef struct {
    bit          we;
    bit          re;
    bit          rdy;
    bit          resp;
    bit          reg_rd;
    bit          mem_ok;
    logic [31:0] rdata;
    logic [31:0] wd;
  } cyc_t;

  typedef struct {
    bit          wr;
    logic [11:0] a;
    logic [2:0]  sz;
    logic [31:0] d;
    logic [31:0] rd;
    int          ws;
    bit          err;
    int          nwe;
    int          nre;
  } vec_t;

  cyc_t        exp_q[$];
  tr_t         pend_q[$];
  logic [11:0] cur_a;
  vec_t        vt[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic bit is_err(input tr_t t);
    bit e;
    e = (t.sz != 3'b010) || (t.a[1:0] != 2'b00);
`ifdef WIFI_AHB_RANGE_CHK_EN
    if (int'(t.a) >= OFS + (1 << 10)) e = 1'b1;
`endif
    return e;
  endfunction

  task automatic expand(input tr_t t);
    cyc_t c;
    c = '{default: 0};
    c.rdy = 1'b1;
    if (is_err(t)) begin
      c.resp = 1'b1;
      c.rdy  = 1'b0;
      exp_q.push_back(c);
      c.rdy = 1'b1;
      exp_q.push_back(c);
    end else if (t.wr) begin
      c.we = 1'b1;
      c.wd = t.d;
      exp_q.push_back(c);
    end else if (int'(t.a) < OFS) begin
      c.re     = 1'b1;
      c.reg_rd = 1'b1;
      exp_q.push_back(c);
    end else begin
      c.re  = 1'b1;
      c.rdy = 1'b0;
      exp_q.push_back(c);
      c.re = 1'b0;
      for (int i = 1; i < LAT; i++) exp_q.push_back(c);
      c.rdy    = 1'b1;
      c.mem_ok = 1'b1;
      c.rdata  = t.d;
      exp_q.push_back(c);
    end
  endtask

  function automatic tr_t rand_tr();
    tr_t t;
    t.wr = 1'($urandom_range(0, 1));
    t.d  = $urandom;
    t.sz = 3'b010;
    case ($urandom_range(0, 5))
      0, 1: t.a = 12'(4 * $urandom_range(0, 3));
      2, 3: t.a = 12'(OFS + 4 * $urandom_range(0, 1019));
      4:    t.a = 12'('h410 + 4 * $urandom_range(0, 763));
      default: begin
        t.a  = 12'($urandom);
        t.sz = 3'($urandom);
      end
    endcase
    return t;
  endfunction

  task automatic junk(input bit busy);
    int k;
    k = $urandom_range(0, 2);
    hsel   = (k == 1) || (k == 2 && busy);
    htrans = (k == 1) ? 2'($urandom_range(0, 1)) : 2'($urandom);
    haddr  = 12'($urandom);
    hwrite = 1'($urandom);
    hsize  = 3'($urandom);
  endtask

  task automatic cycle(input bit may_issue);
    cyc_t c;
    tr_t  t;
    bit   issue;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) c = exp_q.pop_front();
    else begin
      c     = '{default: 0};
      c.rdy = 1'b1;
    end
    hwdata    = c.we ? c.wd : $urandom;
    reg_rdata = $urandom;
    mem_rdata = c.mem_ok ? c.rdata : $urandom;
    if (c.reg_rd) c.rdata = reg_rdata;
    issue = 1'b0;
    if (c.rdy && may_issue &&
        (pend_q.size() > 0 || $urandom_range(0, 3) != 0)) begin
      t     = (pend_q.size() > 0) ? pend_q.pop_front() : rand_tr();
      issue = 1'b1;
    end
    if (issue) begin
      hsel   = 1'b1;
      htrans = 2'b10 | 2'($urandom_range(0, 1));
      haddr  = t.a;
      hwrite = t.wr;
      hsize  = t.sz;
      expand(t);
    end else begin
      junk(!c.rdy);
    end
    @(negedge clk);
    chk("rdy", 32'(hreadyout), 32'(c.rdy));
    chk("resp", 32'(hresp), 32'(c.resp));
    chk("we", 32'(we), 32'(c.we));
    chk("re", 32'(re), 32'(c.re));
    chk("rdata", hrdata, (c.reg_rd || c.mem_ok) ? c.rdata : 32'h0);
    chk("addr", 32'(addr_o), 32'(cur_a));
    if (c.we) chk("wdata", wdata_o, c.wd);
    if (issue) cur_a = t.a;
  endtask

  task automatic single(input vec_t v, input int idx);
    int ws, nresp, nwe, nre;
    bit done;
    ws = 0; nresp = 0; nwe = 0; nre = 0; done = 1'b0;
    @(posedge clk);
    #1;
    hsel      = 1'b1;
    htrans    = 2'b10;
    haddr     = v.a;
    hwrite    = v.wr;
    hsize     = v.sz;
    hwdata    = $urandom;
    reg_rdata = v.rd;
    mem_rdata = v.rd;
    for (int i = 0; i < 10 && !done; i++) begin
      @(posedge clk);
      #1;
      hsel   = 1'b0;
      htrans = 2'b00;
      hwdata = v.d;
      @(negedge clk);
      nwe   += int'(we);
      nre   += int'(re);
      nresp += int'(hresp);
      if (!hreadyout) ws++;
      else begin
        done = 1'b1;
        chk($sformatf("v%0d addr", idx), 32'(addr_o), 32'(v.a));
        if (!v.err && !v.wr)
          chk($sformatf("v%0d rdata", idx), hrdata, v.rd);
        if (!v.err && v.wr)
          chk($sformatf("v%0d wdata", idx), wdata_o, v.d);
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL v%0d timeout: HREADYOUT never rose", idx);
    end
    chk($sformatf("v%0d waits", idx), 32'(ws), 32'(v.ws));
    chk($sformatf("v%0d resp", idx), 32'(nresp), v.err ? 32'd2 : 32'd0);
    chk($sformatf("v%0d nwe", idx), 32'(nwe), 32'(v.nwe));
    chk($sformatf("v%0d nre", idx), 32'(nre), 32'(v.nre));
  endtask

  initial begin
    vt[0] = '{wr:1, a:12'h004, sz:3'b010, d:32'hDEADBEEF, rd:32'h0,
              ws:0, err:0, nwe:1, nre:0};
    vt[1] = '{wr:0, a:12'h008, sz:3'b010, d:32'h0, rd:32'h12345678,
              ws:0, err:0, nwe:0, nre:1};
    vt[2] = '{wr:0, a:12'h020, sz:3'b010, d:32'h0, rd:32'hA5A5A5A5,
              ws:LAT, err:0, nwe:0, nre:1};
    vt[3] = '{wr:1, a:12'h010, sz:3'b000, d:32'h11111111, rd:32'h0,
              ws:1, err:1, nwe:0, nre:0};
    vt[4] = '{wr:0, a:12'h013, sz:3'b010, d:32'h0, rd:32'h0,
              ws:1, err:1, nwe:0, nre:0};
`ifdef WIFI_AHB_RANGE_CHK_EN
    vt[5] = '{wr:0, a:12'h410, sz:3'b010, d:32'h0, rd:32'h5A5A0F0F,
              ws:1, err:1, nwe:0, nre:0};
`else
    vt[5] = '{wr:0, a:12'h410, sz:3'b010, d:32'h0, rd:32'h5A5A0F0F,
              ws:LAT, err:0, nwe:0, nre:1};
`endif
    vt[6] = '{wr:1, a:12'h3FC, sz:3'b010, d:32'h01234567, rd:32'h0,
              ws:0, err:0, nwe:1, nre:0};
    vt[7] = '{wr:0, a:12'h00C, sz:3'b001, d:32'h0, rd:32'h0,
              ws:1, err:1, nwe:0, nre:0};

    rst_n     = 1'b0;
    hsel      = 1'b1;
    htrans    = 2'b10;
    haddr     = 12'h004;
    hwrite    = 1'b1;
    hsize     = 3'b010;
    hwdata    = 32'hFFFFFFFF;
    reg_rdata = 32'hFFFFFFFF;
    mem_rdata = 32'hFFFFFFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst rdy", 32'(hreadyout), 32'd1);
    chk("rst resp", 32'(hresp), 32'd0);
    chk("rst rdata", hrdata, 32'd0);
    chk("rst addr", 32'(addr_o), 32'd0);
    chk("rst wdata", wdata_o, 32'd0);
    chk("rst we", 32'(we), 32'd0);
    chk("rst re", 32'(re), 32'd0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    hsel   = 1'b0;
    htrans = 2'b00;

    for (int i = 0; i < 8; i++) single(vt[i], i);

    // reset while a memory read is waiting
    @(posedge clk);
    #1;
    hsel      = 1'b1;
    htrans    = 2'b10;
    haddr     = 12'h040;
    hwrite    = 1'b0;
    hsize     = 3'b010;
    mem_rdata = 32'hC3C3C3C3;
    @(posedge clk);
    #1;
    hsel   = 1'b0;
    htrans = 2'b00;
    @(negedge clk);
    chk("mrst re", 32'(re), 32'd1);
    chk("mrst rdy0", 32'(hreadyout), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("mrst wait", 32'(hreadyout), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst rdy", 32'(hreadyout), 32'd1);
    chk("mrst rdata", hrdata, 32'd0);
    chk("mrst addr", 32'(addr_o), 32'd0);
    chk("mrst re0", 32'(re), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (LAT + 3) begin
      @(negedge clk);
      chk("post we", 32'(we), 32'd0);
      chk("post re", 32'(re), 32'd0);
      chk("post rdy", 32'(hreadyout), 32'd1);
      chk("post rdata", hrdata, 32'd0);
    end

    cur_a = 12'h0;
    pend_q.push_back('{wr:0, a:12'h020, sz:3'b010, d:32'hA5A5A5A5});
    pend_q.push_back('{wr:1, a:12'h024, sz:3'b010, d:32'h0BADF00D});
    pend_q.push_back('{wr:0, a:12'h008, sz:3'b010, d:32'h0});
    pend_q.push_back('{wr:1, a:12'h00C, sz:3'b010, d:32'h13572468});
    for (int i = 0; i < 800; i++) cycle(1'b1);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle(1'b0);
    cycle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
